uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_pkg.sv | 28 ++
 rtl/uart_cmd_frame_timer.sv | 41 ++++
 rtl/uart_cmd_parser.sv | 193 +++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command parser.
//   - Opcode byte values recognised in IDLE.
//   - FSM state encoding. It is shared so the parser, the frame timer and any
//     checker bound to the debug state port agree on one encoding.
//   - Width of the ALU function field.
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

   localparam logic [7:0] OPC_WRITE   = 8'hAA;  // write: addr, data
   localparam logic [7:0] OPC_READ    = 8'hBB;  // read: addr
   localparam logic [7:0] OPC_ALU_OP  = 8'hCC;  // ALU with operands: A, B, fun
   localparam logic [7:0] OPC_ALU_NOP = 8'hDD;  // ALU without operands: fun

   localparam int ALU_FUN_W = 4;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_ADDR = 3'd1,
      S_WR_DATA = 3'd2,
      S_RD_ADDR = 3'd3,
      S_ALU_OPA = 3'd4,
      S_ALU_OPB = 3'd5,
      S_ALU_FUN = 3'd6
   } state_t;

endpackage

// File: rtl/uart_cmd_frame_timer.sv
// -----------------------------------------------------------------------------
// uart_cmd_frame_timer
// Inter-byte silence counter for one command frame. Only instantiated when
// UART_CMD_FRAME_TIMEOUT_EN is defined.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   i_clear    in   hold the count at zero (parser idle, or a byte accepted)
//   o_expired  out  count has reached Timeout_Cycles-1
//
// The counter saturates at Timeout_Cycles-1 so o_expired cannot wrap away if
// the parser is slow to clear it.
// -----------------------------------------------------------------------------
module uart_cmd_frame_timer #(
   parameter int Timeout_Cycles = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   output logic o_expired
);

   localparam int Cnt_W = (Timeout_Cycles > 1) ? $clog2(Timeout_Cycles) : 1;
   localparam logic [Cnt_W-1:0] Cnt_Last = Cnt_W'(Timeout_Cycles - 1);

   logic [Cnt_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (r_count != Cnt_Last) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = (r_count == Cnt_Last);

endmodule

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
// Decodes byte frames from a UART receiver into register read/write strobes
// and ALU start requests.
//
// Frames (first byte is the opcode):
//   0xAA addr data     -> Wr_En
//   0xBB addr          -> Rd_En
//   0xCC opa opb fun   -> ALU_En
//   0xDD fun           -> ALU_En (Op_A/Op_B keep their previous values)
//
// Ports
//   clk, rst               clock, asynchronous active-low reset
//   RX_P_Data              received byte
//   RX_Data_Valid          one-cycle byte strobe; the only cycles the FSM moves
//                          (apart from a frame timeout)
//   RX_Par_Err, RX_Stp_Err byte corruption flags; a corrupted byte is dropped,
//                          the frame abandoned and Cmd_Err pulsed
//   Wr_En, Rd_En, ALU_En   one-cycle strobes, the cycle after the final byte
//   Address, Wr_Data       register interface fields
//   ALU_Fun, Op_A, Op_B    ALU interface fields
//   Cmd_Err                one-cycle pulse: bad opcode, corrupted byte, timeout
//   Busy                   FSM not in IDLE
//   Dbg_State              current FSM state
//
// Handshake: a byte is taken in exactly the cycles where RX_Data_Valid is 1;
// there is no back-pressure. All outputs are registers updated on that edge,
// so a strobe and the fields it qualifies appear together the next cycle.
//
// Configuration: define UART_CMD_FRAME_TIMEOUT_EN to build the frame timer.
// Without it the parser waits indefinitely between bytes of a frame.
// -----------------------------------------------------------------------------
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int Data_Width     = 8,
   parameter int Addr_Width     = 4,
   parameter int Timeout_Cycles = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [Data_Width-1:0] RX_P_Data,
   input  logic                  RX_Data_Valid,
   input  logic                  RX_Par_Err,
   input  logic                  RX_Stp_Err,
   output logic                  Wr_En,
   output logic                  Rd_En,
   output logic [Addr_Width-1:0] Address,
   output logic [Data_Width-1:0] Wr_Data,
   output logic                  ALU_En,
   output logic [ALU_FUN_W-1:0]  ALU_Fun,
   output logic [Data_Width-1:0] Op_A,
   output logic [Data_Width-1:0] Op_B,
   output logic                  Cmd_Err,
   output logic                  Busy,
   output state_t                Dbg_State
);

   // Opcodes widened to the byte width so decode compares the full byte.
   localparam logic [Data_Width-1:0] Opc_Wr     = Data_Width'(OPC_WRITE);
   localparam logic [Data_Width-1:0] Opc_Rd     = Data_Width'(OPC_READ);
   localparam logic [Data_Width-1:0] Opc_Alu_Op = Data_Width'(OPC_ALU_OP);
   localparam logic [Data_Width-1:0] Opc_Alu_Np = Data_Width'(OPC_ALU_NOP);

   state_t                r_state;
   logic                  r_wr_en;
   logic                  r_rd_en;
   logic                  r_alu_en;
   logic                  r_cmd_err;
   logic [Addr_Width-1:0] r_address;
   logic [Data_Width-1:0] r_wr_data;
   logic [ALU_FUN_W-1:0]  r_alu_fun;
   logic [Data_Width-1:0] r_op_a;
   logic [Data_Width-1:0] r_op_b;

   logic                  w_byte_bad;
   logic                  w_timeout;

   assign w_byte_bad = RX_Par_Err | RX_Stp_Err;

`ifdef UART_CMD_FRAME_TIMEOUT_EN
   logic w_timer_clear;
   logic w_timer_expired;

   // The timer runs only while a frame is open and restarts on every byte.
   assign w_timer_clear = (r_state == S_IDLE) | RX_Data_Valid;

   uart_cmd_frame_timer #(
      .Timeout_Cycles (Timeout_Cycles)
   ) u_frame_timer (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_timer_clear),
      .o_expired (w_timer_expired)
   );

   // The saturated count is still visible for the first cycle back in IDLE;
   // gating on state keeps a single expiry from raising Cmd_Err twice.
   assign w_timeout = w_timer_expired & (r_state != S_IDLE);
`else
   // No timer is built; the parameter is only referenced so the interface
   // stays identical between builds. This is a constant 0.
   assign w_timeout = (Timeout_Cycles < 0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         r_alu_en  <= 1'b0;
         r_cmd_err <= 1'b0;
         r_address <= '0;
         r_wr_data <= '0;
         r_alu_fun <= '0;
         r_op_a    <= '0;
         r_op_b    <= '0;
      end else begin
         // Strobes are single-cycle unless re-asserted below.
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         r_alu_en  <= 1'b0;
         r_cmd_err <= 1'b0;

         if (RX_Data_Valid) begin
            if (w_byte_bad) begin
               // Corrupted byte: never decoded, frame abandoned.
               r_state   <= S_IDLE;
               r_cmd_err <= 1'b1;
            end else begin
               case (r_state)
                  S_IDLE: begin
                     case (RX_P_Data)
                        Opc_Wr:     r_state <= S_WR_ADDR;
                        Opc_Rd:     r_state <= S_RD_ADDR;
                        Opc_Alu_Op: r_state <= S_ALU_OPA;
                        Opc_Alu_Np: r_state <= S_ALU_FUN;
                        default:    r_cmd_err <= 1'b1;
                     endcase
                  end
                  S_WR_ADDR: begin
                     r_address <= RX_P_Data[Addr_Width-1:0];
                     r_state   <= S_WR_DATA;
                  end
                  S_WR_DATA: begin
                     r_wr_data <= RX_P_Data;
                     r_wr_en   <= 1'b1;
                     r_state   <= S_IDLE;
                  end
                  S_RD_ADDR: begin
                     r_address <= RX_P_Data[Addr_Width-1:0];
                     r_rd_en   <= 1'b1;
                     r_state   <= S_IDLE;
                  end
                  S_ALU_OPA: begin
                     r_op_a  <= RX_P_Data;
                     r_state <= S_ALU_OPB;
                  end
                  S_ALU_OPB: begin
                     r_op_b  <= RX_P_Data;
                     r_state <= S_ALU_FUN;
                  end
                  S_ALU_FUN: begin
                     r_alu_fun <= RX_P_Data[ALU_FUN_W-1:0];
                     r_alu_en  <= 1'b1;
                     r_state   <= S_IDLE;
                  end
                  default: begin
                     r_state <= S_IDLE;
                  end
               endcase
            end
         end else if (w_timeout) begin
            // A byte in the expiry cycle takes the branch above instead.
            r_state   <= S_IDLE;
            r_cmd_err <= 1'b1;
         end
      end
   end

   assign Wr_En     = r_wr_en;
   assign Rd_En     = r_rd_en;
   assign ALU_En    = r_alu_en;
   assign Cmd_Err   = r_cmd_err;
   assign Address   = r_address;
   assign Wr_Data   = r_wr_data;
   assign ALU_Fun   = r_alu_fun;
   assign Op_A      = r_op_a;
   assign Op_B      = r_op_b;
   assign Busy      = (r_state != S_IDLE);
   assign Dbg_State = r_state;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
// Bench for uart_cmd_parser. The reference model treats a frame as a queue of
// accepted bytes whose length is fixed by the opcode; fields load from the
// byte at their position and a strobe fires when the queue is complete.
// Inputs change on the falling edge, outputs are compared on the next falling
// edge. Frame timeout cases run only when UART_CMD_FRAME_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;
   import uart_cmd_pkg::*;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int TO = 16;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_par;
   logic          rx_stp;
   logic          wr_en, rd_en, alu_en, cmd_err, busy;
   logic [AW-1:0] address;
   logic [DW-1:0] wr_data, op_a, op_b;
   logic [3:0]    alu_fun;
   state_t        dbg_state;

   always #5 clk = ~clk;

   uart_cmd_parser #(
      .Data_Width     (DW),
      .Addr_Width     (AW),
      .Timeout_Cycles (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .RX_P_Data     (rx_data),
      .RX_Data_Valid (rx_valid),
      .RX_Par_Err    (rx_par),
      .RX_Stp_Err    (rx_stp),
      .Wr_En         (wr_en),
      .Rd_En         (rd_en),
      .Address       (address),
      .Wr_Data       (wr_data),
      .ALU_En        (alu_en),
      .ALU_Fun       (alu_fun),
      .Op_A          (op_a),
      .Op_B          (op_b),
      .Cmd_Err       (cmd_err),
      .Busy          (busy),
      .Dbg_State     (dbg_state)
   );

   // ---------------- checking ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]    frame_q[$];   // accepted bytes of the open frame
   int            silent;       // cycles without a byte while a frame is open
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_opa, m_opb;
   logic [3:0]    m_fun;
   bit            e_wr, e_rd, e_alu, e_err;

   function automatic int frame_len(input logic [7:0] opc);
      case (opc)
         8'hAA:   return 3;
         8'hBB:   return 2;
         8'hCC:   return 4;
         8'hDD:   return 2;
         default: return 0;
      endcase
   endfunction

   function automatic void model_reset();
      frame_q.delete();
      silent  = 0;
      m_addr  = '0;
      m_wdata = '0;
      m_opa   = '0;
      m_opb   = '0;
      m_fun   = '0;
      e_wr    = 0;
      e_rd    = 0;
      e_alu   = 0;
      e_err   = 0;
   endfunction

   // Expected outputs after one clock edge with the given inputs.
   function automatic void model_step(input bit v, input logic [7:0] d, input bit bad);
      int pos;
      e_wr  = 0;
      e_rd  = 0;
      e_alu = 0;
      e_err = 0;
      if (v) begin
         silent = 0;
         if (bad) begin
            frame_q.delete();
            e_err = 1;
         end else if (frame_q.size() == 0) begin
            if (frame_len(d) == 0) e_err = 1;
            else frame_q.push_back(d);
         end else begin
            frame_q.push_back(d);
            pos = frame_q.size() - 1;
            case (frame_q[0])
               8'hAA: begin
                  if (pos == 1) m_addr = d[AW-1:0];
                  if (pos == 2) begin m_wdata = d; e_wr = 1; end
               end
               8'hBB: begin
                  m_addr = d[AW-1:0];
                  e_rd   = 1;
               end
               8'hCC: begin
                  if (pos == 1) m_opa = d;
                  if (pos == 2) m_opb = d;
                  if (pos == 3) begin m_fun = d[3:0]; e_alu = 1; end
               end
               default: begin
                  m_fun = d[3:0];
                  e_alu = 1;
               end
            endcase
            if (frame_q.size() == frame_len(frame_q[0])) frame_q.delete();
         end
      end else if (frame_q.size() != 0) begin
`ifdef UART_CMD_FRAME_TIMEOUT_EN
         silent++;
         if (silent == TO) begin
            frame_q.delete();
            silent = 0;
            e_err  = 1;
         end
`endif
      end
   endfunction

   task automatic compare_all();
      check("wr_en",   32'(wr_en),   32'(e_wr));
      check("rd_en",   32'(rd_en),   32'(e_rd));
      check("alu_en",  32'(alu_en),  32'(e_alu));
      check("cmd_err", 32'(cmd_err), 32'(e_err));
      check("busy",    32'(busy),    32'(frame_q.size() != 0));
      check("idle",    32'(dbg_state == S_IDLE), 32'(frame_q.size() == 0));
      check("address", 32'(address), 32'(m_addr));
      check("wr_data", 32'(wr_data), 32'(m_wdata));
      check("op_a",    32'(op_a),    32'(m_opa));
      check("op_b",    32'(op_b),    32'(m_opb));
      check("alu_fun", 32'(alu_fun), 32'(m_fun));
      check("excl",    32'($countones({wr_en, rd_en, alu_en, cmd_err}) <= 1), 32'd1);
   endtask

   // ---------------- driver tasks (called at a falling edge) ----------------
   task automatic tick(input bit v, input logic [7:0] d, input bit pe, input bit se);
      rx_valid = v;
      rx_data  = v ? d : 8'($urandom);
      rx_par   = pe;
      rx_stp   = se;
      model_step(v, d, pe | se);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic send(input logic [7:0] d);
      tick(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic apply_reset(input int n);
      rx_valid = 1'b0;
      rx_par   = 1'b0;
      rx_stp   = 1'b0;
      rst      = 1'b0;
      model_reset();
      #1;
      compare_all();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         compare_all();
      end
      rst = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] opc_tab[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

   initial begin
      rst      = 1'b0;
      rx_valid = 1'b0;
      rx_data  = '0;
      rx_par   = 1'b0;
      rx_stp   = 1'b0;
      @(negedge clk);
      apply_reset(2);

      // Write frame with a gap between bytes.
      send(8'hAA); send(8'h05); idle(3); send(8'h3C);
      check("w39_wr_en", 32'(wr_en), 32'd1);
      check("w39_addr",  32'(address), 32'h5);
      check("w39_data",  32'(wr_data), 32'h3C);
      idle(1);
      check("w39_busy",  32'(busy), 32'd0);

      // ALU frame with operands; upper nibble of the function byte ignored.
      send(8'hCC); send(8'h12); send(8'h34); send(8'hF3);
      check("a40_alu_en", 32'(alu_en), 32'd1);
      check("a40_fun",    32'(alu_fun), 32'h3);
      check("a40_opa",    32'(op_a), 32'h12);
      check("a40_opb",    32'(op_b), 32'h34);
      idle(2);

      // Unknown opcode, then a read.
      send(8'h55);
      check("r41_err", 32'(cmd_err), 32'd1);
      send(8'hBB); send(8'h0A);
      check("r41_rd_en", 32'(rd_en), 32'd1);
      check("r41_addr",  32'(address), 32'hA);
      idle(1);

      // Parity error on the last write byte, then ALU without operands.
      send(8'hAA); send(8'h05); tick(1'b1, 8'h3C, 1'b1, 1'b0);
      check("p42_err", 32'(cmd_err), 32'd1);
      check("p42_busy", 32'(busy), 32'd0);
      send(8'hDD); send(8'h01);
      check("p42_alu_en", 32'(alu_en), 32'd1);
      check("p42_fun",    32'(alu_fun), 32'h1);
      check("p42_opa",    32'(op_a), 32'h12);
      check("p42_opb",    32'(op_b), 32'h34);
      // Framing error on an opcode byte: dropped, not decoded.
      tick(1'b1, 8'hAA, 1'b0, 1'b1);
      idle(1);
      check("stp_idle", 32'(busy), 32'd0);

      // Reset in the middle of a frame.
      send(8'hCC); send(8'h12);
      apply_reset(3);
      check("r43_opa", 32'(op_a), 32'h0);
      idle(2);

`ifdef UART_CMD_FRAME_TIMEOUT_EN
      // Silence after an opcode: error on the TO-th silent cycle.
      send(8'hAA);
      idle(TO - 1);
      check("t44_pre", 32'(cmd_err), 32'd0);
      idle(1);
      check("t44_err",  32'(cmd_err), 32'd1);
      check("t44_idle", 32'(busy), 32'd0);
      idle(3);
      // A byte on the expiry cycle keeps the frame alive.
      send(8'hAA);
      idle(TO - 1);
      send(8'h07);
      check("t44_nerr", 32'(cmd_err), 32'd0);
      check("t44_busy", 32'(busy), 32'd1);
      send(8'h99);
      check("t44_wr", 32'(wr_en), 32'd1);
      idle(2);
`endif

      // Randomised traffic.
      for (int n = 0; n < 2000; n++) begin
         int r;
         r = $urandom_range(0, 999);
         if (r < 4) begin
            @(negedge clk);
            apply_reset($urandom_range(1, 3));
         end else if (r < 12) begin
            idle($urandom_range(TO - 2, TO + 3));
         end else if (r < 480) begin
            logic [7:0] b;
            bit pe, se;
            b  = ($urandom_range(0, 1) == 1) ? opc_tab[$urandom_range(0, 3)] : 8'($urandom);
            pe = ($urandom_range(0, 29) == 0);
            se = ($urandom_range(0, 29) == 0);
            tick(1'b1, b, pe, se);
         end else begin
            tick(1'b0, 8'h00, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
